cache_axi_responder: RTL and testbench

CACHE_AXI_RESPONDER -- requirements
Module: cache_axi_responder

---
 rtl/cache_axi_responder.sv | 159 +++++++++++++++
 tb/tb_cache_axi_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_responder.sv
`timescale 1ns/1ps
// cache_axi_responder
//   Single-outstanding burst responder backed by a 2^MEM_AW x 32-bit
//   byte-writable memory. One read or write burst is in flight at a time.
//   Write wins when both requests arrive together.
//
//   Optional build macro: CACHE_RESP_GAP_EN -- inserts one idle cycle
//   (rvalid low) after every completed read beat except the last.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   axi_ce_i          chip enable; request qualifier in IDLE
//   axi_ren_i / axi_raddr_i / axi_rlen_i   read burst request
//   axi_rready_i      read beat accept
//   axi_rdata_o / axi_rvalid_o             read beat
//   axi_wen_i / axi_waddr_i / axi_wlen_i   write burst request
//   axi_wdata_i / axi_sel_i / axi_wvalid_i / axi_wlast_i   write beat
//   axi_bvalid_o      one-cycle write response
module cache_axi_responder #(
    parameter int READ_LATENCY = 2,
    parameter int MEM_AW       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_ce_i,
    input  logic [3:0]  axi_sel_i,
    input  logic        axi_ren_i,
    input  logic [31:0] axi_raddr_i,
    input  logic [3:0]  axi_rlen_i,
    input  logic        axi_rready_i,
    output logic [31:0] axi_rdata_o,
    output logic        axi_rvalid_o,
    input  logic        axi_wen_i,
    input  logic [31:0] axi_waddr_i,
    input  logic [3:0]  axi_wlen_i,
    input  logic [31:0] axi_wdata_i,
    input  logic        axi_wvalid_i,
    input  logic        axi_wlast_i,
    output logic        axi_bvalid_o
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t              state;
    logic [31:0]         mem [2**MEM_AW];
    logic [MEM_AW-1:0]   rd_idx;
    logic [MEM_AW-1:0]   rd_next;
    logic [MEM_AW-1:0]   wr_idx;
    logic [3:0]          len;
    logic [3:0]          beat;
    logic [3:0]          lat_cnt;
    logic                mem_we;

    // Only the word-index bits of the byte addresses are used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_raddr_i[31:MEM_AW+2], axi_raddr_i[1:0],
                                axi_waddr_i[31:MEM_AW+2], axi_waddr_i[1:0]};

    assign rd_next = rd_idx + 1'b1;   // wraps at top of memory

    // A beat arriving in the reset cycle is dropped; earlier beats stay.
    assign mem_we = (state == WR_DATA) && axi_wvalid_i && !rst;

    // Memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_sel_i[i]) mem[wr_idx][8*i +: 8] <= axi_wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            axi_rvalid_o <= 1'b0;
            axi_bvalid_o <= 1'b0;
            axi_rdata_o  <= 32'h0;
            rd_idx       <= '0;
            wr_idx       <= '0;
            len          <= '0;
            beat         <= '0;
            lat_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    axi_bvalid_o <= 1'b0;
                    beat         <= '0;
                    if (axi_ce_i && axi_wen_i) begin
                        wr_idx <= axi_waddr_i[MEM_AW+1:2];
                        len    <= axi_wlen_i;
                        state  <= WR_DATA;
                    end else if (axi_ce_i && axi_ren_i) begin
                        rd_idx <= axi_raddr_i[MEM_AW+1:2];
                        len    <= axi_rlen_i;
                        if (READ_LATENCY == 1) begin
                            // Latency 1 leaves no wait cycle: present beat 0 now.
                            axi_rvalid_o <= 1'b1;
                            axi_rdata_o  <= mem[axi_raddr_i[MEM_AW+1:2]];
                            state        <= RD_DATA;
                        end else begin
                            lat_cnt <= 4'(READ_LATENCY - 1);
                            state   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        axi_rvalid_o <= 1'b1;
                        axi_rdata_o  <= mem[rd_idx];
                        state        <= RD_DATA;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (axi_rvalid_o && axi_rready_i) begin
                        if (beat == len) begin
                            axi_rvalid_o <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            beat   <= beat + 4'd1;
                            rd_idx <= rd_next;
`ifdef CACHE_RESP_GAP_EN
                            axi_rvalid_o <= 1'b0;
`else
                            axi_rdata_o  <= mem[rd_next];
`endif
                        end
                    end
`ifdef CACHE_RESP_GAP_EN
                    else if (!axi_rvalid_o) begin
                        // End of the idle gap: present the next beat.
                        axi_rvalid_o <= 1'b1;
                        axi_rdata_o  <= mem[rd_idx];
                    end
`endif
                end
                WR_DATA: begin
                    if (axi_wvalid_i) begin
                        if (axi_wlast_i || beat == len) begin
                            axi_bvalid_o <= 1'b1;
                            state        <= WR_RESP;
                        end else begin
                            beat   <= beat + 4'd1;
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    axi_bvalid_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_responder.sv
`timescale 1ns/1ps
// Self-checking bench for cache_axi_responder: directed scenarios plus a
// randomized write/read mix, checked against a byte-level memory model.
module tb_cache_axi_responder;
    localparam int LAT   = 2;
    localparam int WORDS = 1024;

    logic        clk = 0;
    logic        rst;
    logic        ce;
    logic [3:0]  sel;
    logic        ren;
    logic [31:0] raddr;
    logic [3:0]  rlen;
    logic        rready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wen;
    logic [31:0] waddr;
    logic [3:0]  wlen;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wlast;
    logic        bvalid;

    cache_axi_responder #(.READ_LATENCY(LAT), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst), .axi_ce_i(ce), .axi_sel_i(sel),
        .axi_ren_i(ren), .axi_raddr_i(raddr), .axi_rlen_i(rlen),
        .axi_rready_i(rready), .axi_rdata_o(rdata), .axi_rvalid_o(rvalid),
        .axi_wen_i(wen), .axi_waddr_i(waddr), .axi_wlen_i(wlen),
        .axi_wdata_i(wdata), .axi_wvalid_i(wvalid), .axi_wlast_i(wlast),
        .axi_bvalid_o(bvalid)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference memory: data plus a per-byte "has been written" mask.
    logic [31:0] mdat [WORDS];
    logic [3:0]  mkb  [WORDS];
    logic [31:0] wd   [16];
    logic [3:0]  ws   [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int last_at);
        int fin  = (last_at >= 0 && last_at < len) ? last_at : len;
        int base = int'(addr[11:2]);
        // Request cycle carries junk beat data that must not be written.
        ce = 1; wen = 1; waddr = addr; wlen = len[3:0];
        wvalid = 1; wdata = 32'hDEADBEEF; sel = 4'hF; wlast = 0;
        step;
        wen = 0; wvalid = 0;
        for (int k = 0; k <= fin; k++) begin
            repeat ($urandom_range(0, 2)) step;
            wvalid = 1; wdata = wd[k]; sel = ws[k]; wlast = (k == last_at);
            step;
            for (int i = 0; i < 4; i++) begin
                if (ws[k][i]) begin
                    mdat[(base + k) % WORDS][8*i +: 8] = wd[k][8*i +: 8];
                    mkb[(base + k) % WORDS][i] = 1'b1;
                end
            end
            if (k == fin) begin
                chk("bvalid", 32'(bvalid), 32'd1);
                chk("no_rvalid_in_wr", 32'(rvalid), 32'd0);
            end
            wvalid = 0; wlast = 0;
        end
        // A beat offered during the response cycle must be ignored.
        wvalid = 1; wdata = $urandom; sel = 4'hF;
        step;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
        wvalid = 0;
    endtask

    // mode 0: random rready; 1: rready always high; 2: rready low 3 cycles on beat 0
    task automatic do_read(input logic [31:0] addr, input int len, input int mode);
        int  base  = int'(addr[11:2]);
        int  k     = 0;
        int  c     = 1;
        int  stall = 0;
        int  idx;
        bit  rr;
        bit  done  = 0;
        ce = 1; ren = 1; raddr = addr; rlen = len[3:0]; rready = 0;
        step;
        ren = 0;
        while (!rvalid && c < 40) begin
            step;
            c++;
        end
        chk("first_rvalid_lat", 32'(c), 32'(LAT));
        for (int g = 0; g < 300 && !done; g++) begin
            chk("rvalid", 32'(rvalid), 32'd1);
            idx = (base + k) % WORDS;
            if (mkb[idx] == 4'hF) chk("rdata", rdata, mdat[idx]);
            case (mode)
                1:       rr = 1;
                2:       begin rr = (k != 0) || (stall >= 3); if (!rr) stall++; end
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            step;
            if (rr) begin
                k++;
                if (k > len) begin
                    chk("rvalid_end", 32'(rvalid), 32'd0);
                    done = 1;
                end else begin
`ifdef CACHE_RESP_GAP_EN
                    chk("gap", 32'(rvalid), 32'd0);
                    step;
`endif
                end
            end
        end
        if (!done) chk("read_done", 32'd0, 32'd1);
        rready = 0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < WORDS; i++) begin mdat[i] = '0; mkb[i] = '0; end
        rst = 1; ce = 0; sel = 0; ren = 0; raddr = 0; rlen = 0; rready = 0;
        wen = 0; waddr = 0; wlen = 0; wdata = 0; wvalid = 0; wlast = 0;
        repeat (3) step;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 0;
        step;

        // Chip enable low: requests ignored.
        ce = 0; ren = 1; wen = 1; raddr = 32'h100; waddr = 32'h100;
        repeat (4) step;
        chk("ce_off_rvalid", 32'(rvalid), 32'd0);
        chk("ce_off_bvalid", 32'(bvalid), 32'd0);
        ren = 0; wen = 0;

        // Basic 4-beat write then read back.
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1) * 32'h11; ws[k] = 4'hF; end
        do_write(32'h100, 3, -1);
        do_read(32'h100, 3, 1);

        // Byte-lane merge.
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        do_write(32'h200, 0, -1);
        wd[0] = 32'h00001100; ws[0] = 4'b0010;
        do_write(32'h200, 0, -1);
        chk("merge_model", mdat[128], 32'hAABB11DD);
        do_read(32'h200, 0, 1);

        // Simultaneous ren/wen: write first, read only afterwards.
        ren = 1; raddr = 32'h100; rlen = 0;
        wd[0] = 32'h01020304; wd[1] = 32'h05060708; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h300, 1, -1);
        do_read(32'h100, 0, 0);

        // Wrap at top of memory, with a 3-cycle rready stall.
        wd[0] = 32'hCAFE0FFC; wd[1] = 32'hBEEF0000;
        do_write(32'hFFC, 1, -1);
        do_read(32'hFFC, 1, 2);

        // Early wlast on beat 2 of an 8-beat burst; beats 3..7 keep old data.
        for (int k = 0; k < 8; k++) begin wd[k] = 32'h4000_0000 + 32'(k); ws[k] = 4'hF; end
        do_write(32'h400, 7, -1);
        for (int k = 0; k < 8; k++) wd[k] = 32'h5000_0000 + 32'(k);
        do_write(32'h400, 7, 2);
        do_read(32'h400, 7, 0);

        // Reset during RD_DATA aborts the burst; memory survives.
        ce = 1; ren = 1; raddr = 32'h100; rlen = 3; rready = 0;
        step;
        ren = 0;
        c = 0;
        while (!rvalid && c < 40) begin step; c++; end
        chk("abort_reached_data", 32'(rvalid), 32'd1);
        rst = 1;
        step;
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        rst = 0;
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(32'h500, 0, -1);
        do_read(32'h100, 3, 0);

        // Randomized mix.
        for (int it = 0; it < 15; it++) begin
            logic [31:0] a;
            int wl, rl;
            a  = {20'h0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
            wl = $urandom_range(0, 15);
            rl = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) begin
                wd[k] = $urandom;
                ws[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            do_write(a, wl, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1);
            do_read(a, rl, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
